core_wb_arbiter: RTL and testbench
==================================

# core_wb_arbiter

Two-to-one Wishbone B4 classic arbiter sitting directly downstream of `core`. It consumes the core's instruction port (`iwbm_*`) and data port (`dwbm_*`) and drives a single shared master port toward the system interconnect. Requests are registered before they reach the bus. Slave responses are routed back combinationally to the granted port. Optionally, hung transactions are terminated by a bus-timeout watchdog.

## Interface

**Parameters**
- `TIMEOUT`, default 1023: cycles a granted transaction may wait for `ack`/`err` before the watchdog fires. Only used with `WB_TIMEOUT_EN`. Legal range 1..65535.

**Ports**
- Reset decided: one clock; `rst_i` is synchronous and active-low.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-low reset.
- `iwbs_cyc_i` in 1: instruction-port cycle, from core `iwbm_cyc_o`.
- `iwbs_stb_i` in 1: instruction-port strobe.
- `iwbs_addr_i` in 32: fetch address.
- `iwbs_dat_o` out 32: fetch data; equals `wbm_dat_i`.
- `iwbs_ack_o` out 1: fetch ack.
- `iwbs_err_o` out 1: fetch error.
- `dwbs_cyc_i` in 1: data-port cycle.
- `dwbs_stb_i` in 1: data-port strobe.
- `dwbs_we_i` in 1: data-port write enable.
- `dwbs_sel_i` in 4: data-port byte selects.
- `dwbs_addr_i` in 32: data address.
- `dwbs_dat_i` in 32: store data.
- `dwbs_dat_o` out 32: load data; equals `wbm_dat_i`.
- `dwbs_ack_o` out 1: data ack.
- `dwbs_err_o` out 1: data error.
- `wbm_cyc_o`, `wbm_stb_o` out 1: shared-bus cycle and strobe.
- `wbm_we_o` out 1: shared-bus write enable.
- `wbm_sel_o` out 4: shared-bus byte selects.
- `wbm_addr_o` out 32: shared-bus address.
- `wbm_dat_o` out 32: shared-bus write data.
- `wbm_dat_i` in 32: slave read data.
- `wbm_ack_i`, `wbm_err_i` in 1: slave ack and error.

## Operation

- **FSM states:** IDLE, IBUS, DBUS. A request means `cyc_i & stb_i`.
- **IDLE, one requester:** grant it.
- **IDLE, both requesting:** grant the port not served last, tracked by the `last_gnt` flop. Reset value of `last_gnt` is I, so the first tie goes to D.
- **On grant:**
  - Latch `addr` into `wbm_addr_o`.
  - Latch `we`, `sel` and `dat` into `wbm_we_o`, `wbm_sel_o` and `wbm_dat_o`. For an I grant these are forced to `we=0`, `sel=4'hF`, `dat=0`.
  - Set `wbm_cyc_o` and `wbm_stb_o` to 1.
  - Update `last_gnt`.
  - Clear the timeout counter.
- **IBUS/DBUS response routing:**
  - `Xwbs_ack_o = granted & wbm_ack_i & ~wbm_err_i & Xwbs_cyc_i`
  - `Xwbs_err_o = granted & (wbm_err_i | timeout_hit) & Xwbs_cyc_i`
  - The non-granted port sees ack=0 and err=0.
- **Ending a transaction:** on `wbm_ack_i | wbm_err_i | timeout_hit`, clear `wbm_cyc_o`/`wbm_stb_o` at the next edge and return to IDLE.
- **ack and err in the same cycle:** err wins; only err is forwarded.
- **Granted master drops `cyc` mid-transaction** (core flush):
  - The shared bus stays held until the slave responds.
  - The response is discarded, because it is gated by `cyc_i`.
  - The FSM then returns to IDLE.
- **Requester withdraws `stb` while in IDLE:** no grant; no spurious bus cycle.
- **Reset:**
  - All `wbm_*` outputs are 0; all `*_ack_o`/`*_err_o` are 0.
  - FSM goes to IDLE; `last_gnt` is I; counter is 0.
  - Reset asserted mid-transaction drops `wbm_cyc_o` at that edge. No response is forwarded during reset.

## Timing

- **Request to bus:** request in IDLE at cycle N gives `wbm_cyc_o`/`wbm_stb_o` high at N+1.
- **Response to master:** slave ack at cycle M reaches the master in cycle M, combinationally.
- **After the response:** `wbm_cyc_o` is low at M+1 (IDLE). Next grant is decided at M+1; the next bus cycle starts at M+2. The minimum gap between bus cycles is 1 idle cycle.
- **Address and data stability:** the latched fields stay stable from N+1 until the cycle after the response, regardless of master-side changes.
- **Minimum transaction latency:** 2 cycles, for a slave acking in the first bus cycle.

## Configuration

- Macro: `WB_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter increments every cycle that `wbm_cyc_o=1` and `wbm_ack_i=wbm_err_i=0`.
  - When the counter equals `TIMEOUT`, `timeout_hit=1` for that cycle. The granted port's err is pulsed and the bus is released next edge.
  - A late slave ack arriving in IDLE is ignored.
- **Undefined:** no counter; `timeout_hit` is tied to 0, and a transaction waits indefinitely for `ack`/`err`.

## Test plan

- **Reset:** hold `rst_i=0` for 3 cycles with both ports requesting -> all outputs 0. First grant after release goes to D (`wbm_addr_o` = `dwbs_addr_i`) at release+1.
- **Single load:** D load at `0x8000_0100`, `sel=F`; slave acks after 2 wait states with `0xDEADBEEF` -> `dwbs_ack_o` high exactly 1 cycle with `dwbs_dat_o=0xDEADBEEF`; `iwbs_ack_o` stays 0.
- **Round-robin:** I and D both request continuously; slave acks immediately -> grants alternate D, I, D, I, with one idle bus cycle between each.
- **Flush abort:** I granted at `0x8000_0000`, then `iwbs_cyc_i` drops before the ack; slave acks 3 cycles later -> `iwbs_ack_o` never asserted; pending D is granted 1 cycle after the ack.
- **Simultaneous ack+err:** D store with `wbm_ack_i` and `wbm_err_i` both high in one cycle -> `dwbs_err_o=1`, `dwbs_ack_o=0`; bus released next cycle.
- **Timeout** (`WB_TIMEOUT_EN`, `TIMEOUT=8`): slave never responds -> `dwbs_err_o` pulses at bus cycle 9 after the grant; `wbm_cyc_o=0` the following cycle. Without the macro -> `wbm_cyc_o` stays 1 for more than 100 cycles.

Source files
------------

// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: two-to-one Wishbone B4 classic arbiter that merges the core's instruction and
// data ports onto one registered master port. Define WB_TIMEOUT_EN to enable the bus watchdog.
module core_wb_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  input  logic [31:0] iwbs_addr_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

  state_t state, state_nxt;
  logic   last_gnt;
  logic   i_req, d_req;
  logic   gnt_i, gnt_d;
  logic   bus_done;
  logic   timeout_hit;
  logic   i_owner, d_owner;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("core_wb_arbiter: TIMEOUT must lie within 1..65535");
  end

  assign i_req    = iwbs_cyc_i & iwbs_stb_i;
  assign d_req    = dwbs_cyc_i & dwbs_stb_i;
  assign bus_done = wbm_ack_i | wbm_err_i | timeout_hit;

  // last_gnt = 1 means the data port was served last, so a tie goes to the instruction port
  always_comb begin
    state_nxt = state;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || !last_gnt)) begin
          gnt_d = 1'b1;
        end else if (i_req) begin
          gnt_i = 1'b1;
        end
        if (gnt_d) begin
          state_nxt = DBUS;
        end else if (gnt_i) begin
          state_nxt = IBUS;
        end
      end
      IBUS, DBUS: begin
        if (bus_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus fields are only loaded on a grant, so they hold through the idle cycle after a response
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      last_gnt   <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= 4'h0;
      wbm_addr_o <= 32'h0;
      wbm_dat_o  <= 32'h0;
    end else if (gnt_d) begin
      last_gnt   <= 1'b1;
      wbm_cyc_o  <= 1'b1;
      wbm_stb_o  <= 1'b1;
      wbm_we_o   <= dwbs_we_i;
      wbm_sel_o  <= dwbs_sel_i;
      wbm_addr_o <= dwbs_addr_i;
      wbm_dat_o  <= dwbs_dat_i;
    end else if (gnt_i) begin
      last_gnt   <= 1'b0;
      wbm_cyc_o  <= 1'b1;
      wbm_stb_o  <= 1'b1;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= 4'hF;
      wbm_addr_o <= iwbs_addr_i;
      wbm_dat_o  <= 32'h0;
    end else if (bus_done) begin
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];

  logic [15:0] to_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      to_cnt <= 16'h0;
    end else if (gnt_i || gnt_d) begin
      to_cnt <= 16'h0;
    end else if (wbm_cyc_o && !wbm_ack_i && !wbm_err_i) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign timeout_hit = wbm_cyc_o && (to_cnt == TIMEOUT_CNT);
`else
  assign timeout_hit = 1'b0;
`endif

  // A flushed master has dropped cyc, which is what discards the late response
  assign i_owner    = rst_i & (state == IBUS);
  assign d_owner    = rst_i & (state == DBUS);
  assign iwbs_ack_o = i_owner & wbm_ack_i & ~wbm_err_i & iwbs_cyc_i;
  assign iwbs_err_o = i_owner & (wbm_err_i | timeout_hit) & iwbs_cyc_i;
  assign dwbs_ack_o = d_owner & wbm_ack_i & ~wbm_err_i & dwbs_cyc_i;
  assign dwbs_err_o = d_owner & (wbm_err_i | timeout_hit) & dwbs_cyc_i;
  assign iwbs_dat_o = wbm_dat_i;
  assign dwbs_dat_o = wbm_dat_i;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb_core_wb_arbiter: random two-master traffic against a transaction-level arbitration model;
// requests are queued when issued and popped by the monitor when the bus is granted.
module tb_core_wb_arbiter;

  localparam int TO = 8;
  localparam int P_NONE = 0, P_I = 1, P_D = 2;
  localparam int MODE_RAND = 0, MODE_ACK = 1, MODE_BOTH = 2, MODE_MUTE = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        icyc = 1'b0, istb = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dcyc = 1'b0, dstb = 1'b0, dwe = 1'b0;
  logic [3:0]  dsel = '0;
  logic [31:0] daddr = '0, ddat = '0;
  logic        sl_ack = 1'b0, sl_err = 1'b0;
  logic [31:0] sl_rdat = '0;

  logic [31:0] iwbs_dat_o, dwbs_dat_o, wbm_addr_o, wbm_dat_o;
  logic        iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;

  core_wb_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .iwbs_cyc_i(icyc), .iwbs_stb_i(istb), .iwbs_addr_i(iaddr),
    .iwbs_dat_o(iwbs_dat_o), .iwbs_ack_o(iwbs_ack_o), .iwbs_err_o(iwbs_err_o),
    .dwbs_cyc_i(dcyc), .dwbs_stb_i(dstb), .dwbs_we_i(dwe), .dwbs_sel_i(dsel),
    .dwbs_addr_i(daddr), .dwbs_dat_i(ddat),
    .dwbs_dat_o(dwbs_dat_o), .dwbs_ack_o(dwbs_ack_o), .dwbs_err_o(dwbs_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(sl_rdat), .wbm_ack_i(sl_ack), .wbm_err_i(sl_err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0, n_errors = 0;
  txn_t exp_i[$], exp_d[$];

  logic i_act = 1'b0, d_act = 1'b0;
  int   i_gap = 0, d_gap = 0, i_age = 0, d_age = 0;
  logic s_iresp = 1'b0, s_dresp = 1'b0;
  logic rand_en = 1'b0, flush_en = 1'b0;
  int   max_gap = 3;
  int   sl_wait_force = -1;
  int   sl_mode = MODE_RAND;
  logic sl_dat_force = 1'b0;
  logic [31:0] sl_dat_val = '0;
  logic sl_busy = 1'b0;
  int   sl_wait = 0;

  int   m_port = P_NONE, m_last = P_I, m_cnt = 0;
  txn_t m_txn = '0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issueI(input logic [31:0] a);
    iaddr = a;
    icyc  = 1'b1;
    istb  = 1'b1;
    i_act = 1'b1;
    i_age = 0;
    exp_i.push_back('{addr: a, we: 1'b0, sel: 4'hF, dat: 32'h0});
  endtask

  task automatic issueD(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    daddr = a;
    dwe   = w;
    dsel  = s;
    ddat  = d;
    dcyc  = 1'b1;
    dstb  = 1'b1;
    d_act = 1'b1;
    d_age = 0;
    exp_d.push_back('{addr: a, we: w, sel: s, dat: d});
  endtask

  // A drop before the grant withdraws the queued request; after the grant it is a flush
  task automatic dropI();
    icyc  = 1'b0;
    istb  = 1'b0;
    i_act = 1'b0;
    i_gap = 20;
    if (exp_i.size() != 0) exp_i.delete();
  endtask

  task automatic applyStimulus();
    int unsigned r;
    if (i_act) begin
      i_age++;
      if (s_iresp) begin
        icyc = 1'b0; istb = 1'b0; i_act = 1'b0;
        i_gap = int'($urandom_range(0, max_gap));
      end else if (flush_en && $urandom_range(0, 19) == 0) begin
        dropI();
      end else if (i_age > 300) begin
        n_checks++; n_errors++;
        $display("[TB] FAIL i_master_wait: waited %0d cycles, required at most 300", i_age);
        dropI();
      end
    end else if (i_gap > 0) begin
      i_gap--;
    end else if (rand_en) begin
      r = $urandom();
      issueI(r & 32'hFFFF_FFFC);
    end

    if (d_act) begin
      d_age++;
      if (s_dresp) begin
        dcyc = 1'b0; dstb = 1'b0; d_act = 1'b0;
        d_gap = int'($urandom_range(0, max_gap));
      end else if (d_age > 300) begin
        n_checks++; n_errors++;
        $display("[TB] FAIL d_master_wait: waited %0d cycles, required at most 300", d_age);
        dcyc = 1'b0; dstb = 1'b0; d_act = 1'b0; d_gap = 20;
        if (exp_d.size() != 0) exp_d.delete();
      end
    end else if (d_gap > 0) begin
      d_gap--;
    end else if (rand_en) begin
      issueD($urandom(), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom());
    end

    sl_ack  = 1'b0;
    sl_err  = 1'b0;
    sl_rdat = sl_dat_force ? sl_dat_val : $urandom();
    if (rst && wbm_cyc_o === 1'b1) begin
      if (!sl_busy) begin
        sl_busy = 1'b1;
        sl_wait = (sl_wait_force >= 0) ? sl_wait_force : int'($urandom_range(0, 3));
      end
      if (sl_mode != MODE_MUTE) begin
        if (sl_wait == 0) begin
          sl_busy = 1'b0;
          r = $urandom_range(0, 15);
          if (sl_mode == MODE_BOTH || (sl_mode == MODE_RAND && r == 0)) begin
            sl_ack = 1'b1; sl_err = 1'b1;
          end else if (sl_mode == MODE_RAND && r < 3) begin
            sl_err = 1'b1;
          end else begin
            sl_ack = 1'b1;
          end
        end else begin
          sl_wait--;
        end
      end
    end else begin
      sl_busy = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((i_act || d_act) && n < 400) begin
      cycle();
      n++;
    end
    n_checks++;
    if (i_act || d_act) begin
      n_errors++;
      $display("[TB] FAIL drain: masters busy after %0d cycles, required idle", n);
    end
    repeat (12) cycle();
  endtask

  // Model: one owner at a time, ties go to the port not served last, grant one cycle after request
  task automatic checkOutput();
    logic hit, gi, gd, ri, rd, empty;
    int   pick;
    gi  = rst && (m_port == P_I);
    gd  = rst && (m_port == P_D);
    hit = 1'b0;
`ifdef WB_TIMEOUT_EN
    hit = (m_port != P_NONE) && (m_cnt == TO);
`endif
    compare("wbm_cyc",  wbm_cyc_o,  m_port != P_NONE);
    compare("wbm_stb",  wbm_stb_o,  m_port != P_NONE);
    compare("wbm_addr", wbm_addr_o, m_txn.addr);
    compare("wbm_we",   wbm_we_o,   m_txn.we);
    compare("wbm_sel",  wbm_sel_o,  m_txn.sel);
    compare("wbm_dat",  wbm_dat_o,  m_txn.dat);
    compare("iwbs_ack", iwbs_ack_o, gi && sl_ack && !sl_err && icyc);
    compare("iwbs_err", iwbs_err_o, gi && (sl_err || hit) && icyc);
    compare("dwbs_ack", dwbs_ack_o, gd && sl_ack && !sl_err && dcyc);
    compare("dwbs_err", dwbs_err_o, gd && (sl_err || hit) && dcyc);
    compare("iwbs_dat", iwbs_dat_o, sl_rdat);
    compare("dwbs_dat", dwbs_dat_o, sl_rdat);

    if (!rst) begin
      m_port = P_NONE; m_last = P_I; m_cnt = 0; m_txn = '0;
    end else if (m_port != P_NONE) begin
      if (sl_ack || sl_err || hit) m_port = P_NONE;
      else m_cnt++;
    end else begin
      ri = icyc && istb;
      rd = dcyc && dstb;
      if (ri || rd) begin
        if (ri && rd) pick = (m_last == P_I) ? P_D : P_I;
        else pick = rd ? P_D : P_I;
        empty = (pick == P_D) ? (exp_d.size() == 0) : (exp_i.size() == 0);
        if (empty) begin
          n_checks++; n_errors++;
          $display("[TB] FAIL scoreboard: grant to port %0d with no queued request, required one", pick);
        end else begin
          m_txn  = (pick == P_D) ? exp_d.pop_front() : exp_i.pop_front();
          m_port = pick;
          m_last = pick;
          m_cnt  = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    s_iresp = iwbs_ack_o | iwbs_err_o;
    s_dresp = dwbs_ack_o | dwbs_err_o;
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    issueI(32'h0000_1000);
    issueD(32'h0000_2000, 1'b1, 4'h3, 32'h1234_5678);
    repeat (3) cycle();
    rst = 1'b1;

    rand_en = 1'b1; flush_en = 1'b1;
    repeat (1500) cycle();
    rand_en = 1'b0; flush_en = 1'b0;
    waitIdle();

    max_gap = 0; sl_wait_force = 0; rand_en = 1'b1;
    repeat (40) cycle();
    rand_en = 1'b0;
    waitIdle();
    max_gap = 3; sl_wait_force = -1;

    sl_wait_force = 2; sl_mode = MODE_ACK; sl_dat_force = 1'b1; sl_dat_val = 32'hDEAD_BEEF;
    issueD(32'h8000_0100, 1'b0, 4'hF, 32'h0);
    waitIdle();
    sl_dat_force = 1'b0;

    sl_wait_force = 4;
    issueI(32'h8000_0000);
    n = 0;
    while (wbm_cyc_o !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    dropI();
    issueD(32'h8000_0200, 1'b1, 4'hC, 32'h0BAD_F00D);
    waitIdle();

    sl_wait_force = 1; sl_mode = MODE_BOTH;
    issueD(32'h4000_0010, 1'b1, 4'h5, 32'hCAFE_F00D);
    waitIdle();

`ifdef WB_TIMEOUT_EN
    sl_mode = MODE_MUTE; sl_wait_force = -1;
    issueD(32'h5000_0000, 1'b0, 4'hF, 32'h0);
    n = 0;
    while (d_act && n < 40) begin
      cycle();
      n++;
    end
    sl_ack = 1'b1;
    cycle();
    waitIdle();
`endif

    sl_mode = MODE_MUTE; sl_wait_force = -1;
    issueD(32'h6000_0000, 1'b0, 4'hF, 32'h0);
`ifdef WB_TIMEOUT_EN
    repeat (4) cycle();
`else
    repeat (120) cycle();
`endif
    rst = 1'b0;
    sl_ack = 1'b1;
    cycle();
    dcyc = 1'b0; dstb = 1'b0; d_act = 1'b0;
    if (exp_d.size() != 0) exp_d.delete();
    cycle();
    rst = 1'b1;
    sl_mode = MODE_RAND;
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
